tag_sched: RTL and testbench
============================

TAG_SCHED -- requirements
Module: tag_sched

Interface
REQ-001 SHALL have parameter NUM_COL, default 8, meaning number of PE columns served.
REQ-002 SHALL have parameter TAG_W, default $clog2(NUM_COL), meaning tag width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  tag request valid.
REQ-006 SHALL have port req_tag  input  TAG_W  requested tag.
REQ-007 SHALL have port req_ready  output  1  scheduler can accept a request.
REQ-008 SHALL have port col_done  input  NUM_COL  per-column completion pulses.
REQ-009 SHALL have port abort  input  1  cancel the current tag.
REQ-010 SHALL have port flush  output  1  one-cycle load strobe to the downstream tag allocator.
REQ-011 SHALL have port tag_in  output  TAG_W  tag presented with flush.
REQ-012 SHALL have port tag_locks  output  NUM_COL  per-column lock; 1 = column locked/masked.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-015 SHALL implement states IDLE, LOAD, SWEEP, WAIT.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on the edge where req_valid&&req_ready.
REQ-017 SHALL, on acceptance at edge T, register req_tag into tag_in and enter LOAD; in the LOAD cycle (T..T+1), flush=1 for exactly one cycle.
REQ-018 SHALL hold tag_in stable from acceptance until the next acceptance; req_tag SHALL be ignored outside IDLE.
REQ-019 SHALL hold tag_locks all-ones in IDLE and LOAD.
REQ-020 SHALL, in SWEEP, clear one lock bit per cycle in ascending order: bit k cleared at edge T+2+k, k=0..NUM_COL-1, using a pointer counter of width $clog2(NUM_COL)+1.
REQ-021 SHALL leave SWEEP for WAIT on the edge that clears bit NUM_COL-1 (pointer SHALL not wrap).
REQ-022 SHALL keep a done_mask register, NUM_COL bits; a col_done[j] pulse sets done_mask[j] only if tag_locks[j]==0 in that cycle (registered value).
REQ-023 SHALL set err on any col_done[j] while tag_locks[j]==1, including the cycle in which bit j is being cleared; that pulse SHALL not set done_mask[j].
REQ-024 SHALL treat a repeated col_done[j] with done_mask[j] already set as a no-op (no error).
REQ-025 SHALL, in WAIT, when done_mask (including pulses of the current cycle) is all-ones, return to IDLE on the next edge, setting tag_locks to all-ones and clearing done_mask on that edge.
REQ-026 SHALL, on abort in any non-IDLE state, on the next edge go to IDLE, set tag_locks all-ones, clear done_mask and pointer, suppress flush; abort has priority over all other transitions; abort in IDLE is ignored and blocks acceptance that cycle.
REQ-027 SHALL allow a new acceptance in the first IDLE cycle after return (back-to-back tags; minimum tag period NUM_COL+3 cycles).
REQ-028 SHALL keep err set until rst; err SHALL not alter state transitions.

Reset
REQ-029 SHALL, on rst sampled high, set: state IDLE, req_ready=1, flush=0, tag_in=0, tag_locks=all-ones, busy=0, err=0, done_mask=0, pointer=0.
REQ-030 SHALL give rst priority over abort, requests and col_done; rst mid-SWEEP/WAIT discards the tag with no flush.

Verification
REQ-031 SHALL cover: NUM_COL=8, req_tag=5 accepted at cycle 0 -> flush=1, tag_in=5 in cycle 1; locks 0xFE at cycle 3 ... 0x00 at cycle 10; busy high cycles 1..end.
REQ-032 SHALL cover: after full sweep, col_done pulses 0x0F then 0xF0 -> locks return to 0xFF and req_ready=1 one cycle after the 0xF0 pulse; err=0.
REQ-033 SHALL cover: col_done[3] while lock bit 3 still set (cycle 5) -> err=1 sticky, done_mask[3]=0; later valid col_done[3] completes normally.
REQ-034 SHALL cover: abort during SWEEP at locks=0xF0 -> next cycle locks=0xFF, IDLE, req_ready=1, no flush.
REQ-035 SHALL cover: req_valid held high continuously with tags 1,2 -> second flush exactly one cycle after IDLE re-entry, tag_in changes only at acceptance.
REQ-036 SHALL cover: rst asserted in WAIT with done_mask=0x3C -> next cycle all REQ-029 values, err cleared.

Source files
------------

// File: rtl/tag_sched.sv
// tag_sched: loads a tag downstream, unlocks PE columns one per cycle, then waits
// until every column has reported completion before accepting the next tag.
module tag_sched #(
    parameter int NUM_COL = 8,
    parameter int TAG_W   = $clog2(NUM_COL)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               req_ready,
    input  logic [NUM_COL-1:0] col_done,
    input  logic               abort,
    output logic               flush,
    output logic [TAG_W-1:0]   tag_in,
    output logic [NUM_COL-1:0] tag_locks,
    output logic               busy,
    output logic               err
);
    localparam int PW = $clog2(NUM_COL) + 1;
    localparam logic [NUM_COL-1:0] ONE = 1;
    typedef enum logic [1:0] {IDLE, LOAD, SWEEP, WAIT} state_t;
    state_t state_q, state_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [NUM_COL-1:0] locks_q, locks_d, mask_q, mask_d, hit;
    logic [PW-1:0] ptr_q, ptr_d;
    logic err_q, err_d;
    always_comb begin
        // only pulses on already-unlocked columns count as completions
        hit = col_done & ~locks_q;
        state_d = state_q;
        tag_d = tag_q;
        locks_d = locks_q;
        mask_d = mask_q | hit;
        ptr_d = ptr_q;
        err_d = err_q | |(col_done & locks_q);
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            locks_d = '1;
            mask_d = '0;
            ptr_d = '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid && !abort) begin
                    state_d = LOAD;
                    tag_d = req_tag;
                end
                LOAD: begin
                    state_d = SWEEP;
                    ptr_d = '0;
                end
                SWEEP: begin
                    locks_d = locks_q & ~(ONE << ptr_q);
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == PW'(NUM_COL - 1)) state_d = WAIT;
                end
                WAIT: if (&mask_d) begin
                    state_d = IDLE;
                    locks_d = '1;
                    mask_d = '0;
                    ptr_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tag_q <= '0;
            locks_q <= '1;
            mask_q <= '0;
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q <= tag_d;
            locks_q <= locks_d;
            mask_q <= mask_d;
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end
    assign req_ready = state_q == IDLE;
    assign flush = state_q == LOAD;
    assign busy = state_q != IDLE;
    assign tag_in = tag_q;
    assign tag_locks = locks_q;
    assign err = err_q;
endmodule

// File: tb/tb_tag_sched.sv
// tb_tag_sched: scoreboard bench; a cycle-age reference model predicts every output per edge.
module tb_tag_sched;
    localparam int N = 8;
    localparam int TW = 3;
    logic clk = 1'b0;
    logic rst, req_valid, req_ready, abort, flush, busy, err;
    logic [TW-1:0] req_tag, tag_in;
    logic [N-1:0] col_done, tag_locks;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic ready, flush, busy, err;
        logic [TW-1:0] tag;
        logic [N-1:0] locks;
    } exp_t;
    exp_t sb[$];
    // model: idle flag plus edges elapsed since acceptance (0 = LOAD cycle)
    bit m_idle = 1'b1;
    int m_age = 0;
    logic [TW-1:0] m_tag = '0;
    logic [N-1:0] m_mask = '0;
    logic m_err = 1'b0;

    tag_sched #(.NUM_COL(N)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_tag(req_tag),
        .req_ready(req_ready), .col_done(col_done), .abort(abort), .flush(flush),
        .tag_in(tag_in), .tag_locks(tag_locks), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_locks();
        int clr;
        logic [N-1:0] v = '1;
        if (m_idle) return v;
        clr = m_age - 1;
        if (clr < 0) clr = 0;
        if (clr > N) clr = N;
        return v << clr;
    endfunction

    task automatic step(input logic rv, input logic [TW-1:0] rt, input logic [N-1:0] cd,
                        input logic ab, input logic rs);
        logic [N-1:0] cur;
        exp_t e, o;
        req_valid = rv; req_tag = rt; col_done = cd; abort = ab; rst = rs;
        cur = m_locks();
        if (rs) begin
            m_idle = 1'b1; m_age = 0; m_tag = '0; m_mask = '0; m_err = 1'b0;
        end else begin
            m_err = m_err | (|(cd & cur));
            if (!m_idle && ab) begin
                m_idle = 1'b1; m_mask = '0;
            end else if (m_idle) begin
                if (rv && !ab) begin
                    m_idle = 1'b0; m_age = 0; m_tag = rt;
                end
            end else begin
                m_mask = m_mask | (cd & ~cur);
                if (m_age >= N + 1 && &m_mask) begin
                    m_idle = 1'b1; m_mask = '0;
                end else m_age++;
            end
        end
        e.ready = m_idle; e.flush = !m_idle && m_age == 0; e.busy = !m_idle;
        e.err = m_err; e.tag = m_tag; e.locks = m_locks();
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check("req_ready", 32'(req_ready), 32'(o.ready));
        check("flush", 32'(flush), 32'(o.flush));
        check("busy", 32'(busy), 32'(o.busy));
        check("err", 32'(err), 32'(o.err));
        check("tag_in", 32'(tag_in), 32'(o.tag));
        check("tag_locks", 32'(tag_locks), 32'(o.locks));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        // full sweep, then completion in two halves
        step(1'b1, 3'd5, '0, 1'b0, 1'b0);
        idle(N + 2);
        step(1'b0, '0, 8'h0F, 1'b0, 1'b0);
        step(1'b0, '0, 8'hF0, 1'b0, 1'b0);
        idle(2);
        // early completion on a locked column raises sticky err
        step(1'b1, 3'd3, '0, 1'b0, 1'b0);
        idle(3);
        step(1'b0, '0, 8'h08, 1'b0, 1'b0);
        idle(N);
        step(1'b0, '0, 8'hF7, 1'b0, 1'b0);
        idle(2);
        step(1'b0, '0, 8'h08, 1'b0, 1'b0);
        step(1'b0, '0, 8'h08, 1'b0, 1'b0);
        // abort mid-sweep; abort in IDLE blocks acceptance
        step(1'b1, 3'd6, '0, 1'b0, 1'b0);
        idle(5);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 3'd7, '0, 1'b1, 1'b0);
        idle(1);
        // back-to-back with req_valid held high
        step(1'b1, 3'd1, '0, 1'b0, 1'b0);
        repeat (N + 2) step(1'b1, 3'd2, '0, 1'b0, 1'b0);
        step(1'b1, 3'd2, 8'hFF, 1'b0, 1'b0);
        repeat (3) step(1'b1, 3'd4, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        // rst in WAIT with partial done mask clears everything including err
        step(1'b1, 3'd4, '0, 1'b0, 1'b0);
        idle(N + 2);
        step(1'b0, '0, 8'h3C, 1'b0, 1'b0);
        step(1'b0, '0, 8'h01, 1'b0, 1'b0);
        step(1'b1, 3'd5, 8'h02, 1'b1, 1'b1);
        idle(1);
        // rst mid-sweep discards tag
        step(1'b1, 3'd6, '0, 1'b0, 1'b0);
        idle(3);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        idle(1);
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), TW'($urandom), N'($urandom & $urandom & $urandom),
                 $urandom_range(0, 29) == 0, $urandom_range(0, 149) == 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
